// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, ALU codes and state encodings for the multicycle control unit
package cpu_pkg;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_L  = 7'b0000011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_LU = 7'b0110111;
    localparam logic [6:0] OP_AU = 7'b0010111;
    localparam logic [6:0] OP_J  = 7'b1101111;
    localparam logic [6:0] OP_JL = 7'b1100111;

    // Codes follow {funct7[5], funct3}; BEQ reuses the subtract encoding.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_BEQ  = 4'b1000;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_R_EXE,
        ST_I_EXE,
        ST_B_EXE,
        ST_LU_EXE,
        ST_AU_EXE,
        ST_J_EXE,
        ST_JL_EXE,
        ST_S_EXE,
        ST_S_MEM,
        ST_L_EXE,
        ST_L_MEM,
        ST_L_WB,
        ST_TRAP
    } state_e;

    typedef enum logic [1:0] {
        WD_ALU  = 2'd0,
        WD_MEM  = 2'd1,
        WD_UIMM = 2'd2,
        WD_PC4  = 2'd3
    } wdsel_e;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - instruction/datapath control bundle between control unit and datapath
interface multicycle_control_unit_if #(
    parameter int ALU_CTRL_W = 4
);
    logic [31:0]           instrCode;
    logic                  compare;
    logic                  dmem_ready;
    logic                  pcEn;
    logic                  regFileWe;
    logic [ALU_CTRL_W-1:0] aluControl;
    logic                  aluSrcMuxSel;
    logic                  alurd1MuxSel;
    logic                  dataWe;
    logic                  dataRe;
    logic [1:0]            rfWdSrcMuxSel;
    logic                  PCAddrSrcMuxSel;
    logic                  jalrSel;
    logic                  illegalInstr;
    logic                  busErr;

    modport master (
        input  instrCode, compare, dmem_ready,
        output pcEn, regFileWe, aluControl, aluSrcMuxSel, alurd1MuxSel,
               dataWe, dataRe, rfWdSrcMuxSel, PCAddrSrcMuxSel, jalrSel,
               illegalInstr, busErr
    );

    modport slave (
        output instrCode, compare, dmem_ready,
        input  pcEn, regFileWe, aluControl, aluSrcMuxSel, alurd1MuxSel,
               dataWe, dataRe, rfWdSrcMuxSel, PCAddrSrcMuxSel, jalrSel,
               illegalInstr, busErr
    );
endinterface

// File: rtl/cu_alu_decoder.sv
// rtl/cu_alu_decoder.sv - maps opcode/funct fields to an ALU operation and an opcode-legal flag
module cu_alu_decoder
    import cpu_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic       instr30_i,
    input  logic [2:0] funct3_i,
    output logic [3:0] alu_ctrl_o,
    output logic       legal_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        legal_o    = 1'b1;
        case (opcode_i)
            OP_R:  alu_ctrl_o = {instr30_i, funct3_i};
            // instr[30] is immediate data for I-type, except for SRAI.
            OP_I:  alu_ctrl_o = ({instr30_i, funct3_i} == ALU_SRA) ? ALU_SRA : {1'b0, funct3_i};
            OP_S, OP_L, OP_AU, OP_JL, OP_LU, OP_J: alu_ctrl_o = ALU_ADD;
            OP_B: begin
                case (funct3_i[2:1])
                    2'b00:   alu_ctrl_o = ALU_BEQ;
                    2'b10:   alu_ctrl_o = ALU_SLT;
                    2'b11:   alu_ctrl_o = ALU_SLTU;
                    default: legal_o    = 1'b0;
                endcase
            end
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle RV32I sequencer with memory wait timeout and sticky traps
module multicycle_control_unit
    import cpu_pkg::*;
#(
    parameter int ALU_CTRL_W     = 4,
    parameter int MEM_HANDSHAKE  = 1,
    parameter int TIMEOUT_CYCLES = 15
) (
    input logic clk,
    input logic reset_n,
    multicycle_control_unit_if.master bus
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [3:0] dec_alu;
    logic       op_legal;
    logic       mem_done;
    logic       wait_expired;

    assign opcode       = bus.instrCode[6:0];
    assign funct3       = bus.instrCode[14:12];
    assign mem_done     = (MEM_HANDSHAKE != 0) ? bus.dmem_ready : 1'b1;
    assign wait_expired = (cnt_q == CNT_LAST);

    cu_alu_decoder u_alu_decoder (
        .opcode_i  (opcode),
        .instr30_i (bus.instrCode[30]),
        .funct3_i  (funct3),
        .alu_ctrl_o(dec_alu),
        .legal_o   (op_legal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        case (state_q)
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                if (!op_legal) begin
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    case (opcode)
                        OP_R:    state_d = ST_R_EXE;
                        OP_I:    state_d = ST_I_EXE;
                        OP_S:    state_d = ST_S_EXE;
                        OP_L:    state_d = ST_L_EXE;
                        OP_B:    state_d = ST_B_EXE;
                        OP_LU:   state_d = ST_LU_EXE;
                        OP_AU:   state_d = ST_AU_EXE;
                        OP_J:    state_d = ST_J_EXE;
                        OP_JL:   state_d = ST_JL_EXE;
                        default: state_d = ST_TRAP;
                    endcase
                end
            end
            ST_R_EXE, ST_I_EXE, ST_B_EXE, ST_LU_EXE, ST_AU_EXE, ST_J_EXE, ST_JL_EXE, ST_L_WB:
                state_d = ST_FETCH;
            ST_S_EXE: begin
                state_d = ST_S_MEM;
                cnt_d   = '0;
            end
            ST_L_EXE: begin
                state_d = ST_L_MEM;
                cnt_d   = '0;
            end
            ST_S_MEM, ST_L_MEM: begin
                // A ready in the final wait cycle still completes the access.
                if (mem_done) begin
                    state_d = (state_q == ST_S_MEM) ? ST_FETCH : ST_L_WB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (wait_expired) begin
                        state_d   = ST_TRAP;
                        bus_err_d = 1'b1;
                    end
                end
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
    end

    logic   pc_en, rf_we, alu_src, alu_rd1, data_we, data_re, pc_addr_sel, jalr_sel;
    wdsel_e wd_sel;
    logic [3:0] alu_sel;

    always_comb begin
        pc_en       = 1'b0;
        rf_we       = 1'b0;
        alu_src     = 1'b0;
        alu_rd1     = 1'b0;
        data_we     = 1'b0;
        data_re     = 1'b0;
        pc_addr_sel = 1'b0;
        jalr_sel    = 1'b0;
        wd_sel      = WD_ALU;
        alu_sel     = ALU_ADD;
        case (state_q)
            ST_R_EXE: begin
                rf_we = 1'b1; pc_en = 1'b1; alu_sel = dec_alu;
            end
            ST_I_EXE: begin
                rf_we = 1'b1; alu_src = 1'b1; pc_en = 1'b1; alu_sel = dec_alu;
            end
            ST_LU_EXE: begin
                rf_we = 1'b1; wd_sel = WD_UIMM; pc_en = 1'b1; alu_sel = dec_alu;
            end
            ST_AU_EXE: begin
                rf_we = 1'b1; alu_rd1 = 1'b1; alu_src = 1'b1; pc_en = 1'b1; alu_sel = dec_alu;
            end
            ST_B_EXE: begin
                pc_addr_sel = bus.compare ^ funct3[0]; pc_en = 1'b1; alu_sel = dec_alu;
            end
            ST_J_EXE: begin
                rf_we = 1'b1; wd_sel = WD_PC4; pc_addr_sel = 1'b1; pc_en = 1'b1; alu_sel = dec_alu;
            end
            ST_JL_EXE: begin
                rf_we = 1'b1; wd_sel = WD_PC4; alu_src = 1'b1; jalr_sel = 1'b1; pc_en = 1'b1;
                alu_sel = dec_alu;
            end
            ST_S_EXE, ST_L_EXE: begin
                alu_src = 1'b1; alu_sel = dec_alu;
            end
            ST_S_MEM: begin
                alu_src = 1'b1; data_we = 1'b1; pc_en = mem_done; alu_sel = dec_alu;
            end
            ST_L_MEM: begin
                alu_src = 1'b1; data_re = 1'b1; alu_sel = dec_alu;
            end
            ST_L_WB: begin
                rf_we = 1'b1; wd_sel = WD_MEM; pc_en = 1'b1; alu_sel = dec_alu;
            end
            default: ;
        endcase
    end

    assign bus.pcEn            = pc_en;
    assign bus.regFileWe       = rf_we;
    assign bus.aluControl      = ALU_CTRL_W'(alu_sel);
    assign bus.aluSrcMuxSel    = alu_src;
    assign bus.alurd1MuxSel    = alu_rd1;
    assign bus.dataWe          = data_we;
    assign bus.dataRe          = data_re;
    assign bus.rfWdSrcMuxSel   = wd_sel;
    assign bus.PCAddrSrcMuxSel = pc_addr_sel;
    assign bus.jalrSel         = jalr_sel;
    assign bus.illegalInstr    = illegal_q;
    assign bus.busErr          = bus_err_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] instr;
    logic        compare;
    logic        ready;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    multicycle_control_unit_if #(.ALU_CTRL_W(4)) bus0 ();
    multicycle_control_unit_if #(.ALU_CTRL_W(4)) bus1 ();

    assign bus0.instrCode  = instr;
    assign bus0.compare    = compare;
    assign bus0.dmem_ready = ready;
    assign bus1.instrCode  = instr;
    assign bus1.compare    = compare;
    assign bus1.dmem_ready = ready;

    multicycle_control_unit #(.ALU_CTRL_W(4), .MEM_HANDSHAKE(1), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus0)
    );
    multicycle_control_unit #(.ALU_CTRL_W(4), .MEM_HANDSHAKE(0), .TIMEOUT_CYCLES(15)) dut_nohs (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );

    // {pcEn, regFileWe, aluSrc, alurd1, dataWe, dataRe, rfWdSrc[1:0], PCAddrSrc, jalrSel}
    logic [9:0] ctl0, ctl1;
    assign ctl0 = {bus0.pcEn, bus0.regFileWe, bus0.aluSrcMuxSel, bus0.alurd1MuxSel, bus0.dataWe,
                   bus0.dataRe, bus0.rfWdSrcMuxSel, bus0.PCAddrSrcMuxSel, bus0.jalrSel};
    assign ctl1 = {bus1.pcEn, bus1.regFileWe, bus1.aluSrcMuxSel, bus1.alurd1MuxSel, bus1.dataWe,
                   bus1.dataRe, bus1.rfWdSrcMuxSel, bus1.PCAddrSrcMuxSel, bus1.jalrSel};

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] ins, input logic cmp);
        reset_n = 1'b0;
        instr   = ins;
        compare = cmp;
        ready   = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        instr   = 32'h002081B3;
        compare = 1'b0;
        ready   = 1'b0;
        #3;
        checks++;
        if (ctl0 !== 10'b0 || bus0.aluControl !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: ctl=%b alu=%b expected ctl=0 alu=0000", ctl0, bus0.aluControl);
        end
        checks++;
        if (bus0.illegalInstr !== 1'b0 || bus0.busErr !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: illegal=%b busErr=%b expected 0 0", bus0.illegalInstr, bus0.busErr);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ctl0 !== 10'b0) begin
            errors++;
            $display("FAIL reset_held: ctl=%b expected 0", ctl0);
        end
    endtask

    task automatic test_alu_ops();
        logic [31:0] ins [8];
        logic [9:0]  ectl[8];
        logic [3:0]  ealu[8];
        int          npc;
        ins[0] = 32'h002081B3;                                           ectl[0] = 10'b1100000000; ealu[0] = 4'b0000;
        ins[1] = 32'h402081B3;                                           ectl[1] = 10'b1100000000; ealu[1] = 4'b1000;
        ins[2] = {7'b0100000, 5'd3, 5'd1, 3'b101, 5'd3, 7'b0010011};    ectl[2] = 10'b1110000000; ealu[2] = 4'b1101;
        ins[3] = {12'h400, 5'd1, 3'b000, 5'd3, 7'b0010011};             ectl[3] = 10'b1110000000; ealu[3] = 4'b0000;
        ins[4] = {20'h12345, 5'd3, 7'b0110111};                         ectl[4] = 10'b1100001000; ealu[4] = 4'b0000;
        ins[5] = {20'h12345, 5'd3, 7'b0010111};                         ectl[5] = 10'b1111000000; ealu[5] = 4'b0000;
        ins[6] = {20'h00100, 5'd1, 7'b1101111};                         ectl[6] = 10'b1100001110; ealu[6] = 4'b0000;
        ins[7] = {12'h004, 5'd2, 3'b000, 5'd1, 7'b1100111};             ectl[7] = 10'b1110001101; ealu[7] = 4'b0000;
        for (int t = 0; t < 8; t++) begin
            start(ins[t], 1'b0);
            npc = 0;
            #1;
            for (int c = 1; c <= 4; c++) begin
                if (c > 1) step();
                npc += int'(ctl0[9]);
                checks++;
                if (ctl0 !== ((c == 3) ? ectl[t] : 10'b0)) begin
                    errors++;
                    $display("FAIL alu_ops[%0d] cycle %0d: ctl=%b expected %b", t, c, ctl0,
                             (c == 3) ? ectl[t] : 10'b0);
                end
                if (c == 3) begin
                    checks++;
                    if (bus0.aluControl !== ealu[t]) begin
                        errors++;
                        $display("FAIL alu_ops[%0d] aluControl: got %b expected %b", t, bus0.aluControl, ealu[t]);
                    end
                end
            end
            checks++;
            if (npc != 1) begin
                errors++;
                $display("FAIL alu_ops[%0d] pcEn_count: got %0d expected 1", t, npc);
            end
        end
    endtask

    task automatic test_branch();
        logic [2:0] f3  [5];
        logic       cmp [5];
        logic [9:0] ectl[5];
        logic [3:0] ealu[5];
        f3[0] = 3'b001; cmp[0] = 1'b0; ectl[0] = 10'b1000000010; ealu[0] = 4'b1000;
        f3[1] = 3'b001; cmp[1] = 1'b1; ectl[1] = 10'b1000000000; ealu[1] = 4'b1000;
        f3[2] = 3'b111; cmp[2] = 1'b1; ectl[2] = 10'b1000000000; ealu[2] = 4'b0011;
        f3[3] = 3'b110; cmp[3] = 1'b1; ectl[3] = 10'b1000000010; ealu[3] = 4'b0011;
        f3[4] = 3'b100; cmp[4] = 1'b0; ectl[4] = 10'b1000000000; ealu[4] = 4'b0010;
        for (int t = 0; t < 5; t++) begin
            start({7'b0, 5'd2, 5'd1, f3[t], 5'b01000, 7'b1100011}, cmp[t]);
            #1;
            step();
            step();
            checks++;
            if (ctl0 !== ectl[t] || bus0.aluControl !== ealu[t]) begin
                errors++;
                $display("FAIL branch[%0d]: ctl=%b alu=%b expected ctl=%b alu=%b", t, ctl0,
                         bus0.aluControl, ectl[t], ealu[t]);
            end
        end
    endtask

    task automatic test_load_wait();
        logic [9:0] e;
        int npc, nre;
        start({12'd4, 5'd1, 3'b010, 5'd3, 7'b0000011}, 1'b0);
        npc = 0;
        nre = 0;
        for (int c = 1; c <= 9; c++) begin
            if (c > 1) step();
            ready = (c == 7);
            #1;
            npc += int'(ctl0[9]);
            nre += int'(ctl0[4]);
            if (c == 3)                e = 10'b0010000000;
            else if (c >= 4 && c <= 7) e = 10'b0010010000;
            else if (c == 8)           e = 10'b1100000100;
            else                       e = 10'b0;
            checks++;
            if (ctl0 !== e) begin
                errors++;
                $display("FAIL load_wait cycle %0d: ctl=%b expected %b", c, ctl0, e);
            end
        end
        checks++;
        if (npc != 1 || nre != 4) begin
            errors++;
            $display("FAIL load_counts: pcEn=%0d dataRe=%0d expected 1 4", npc, nre);
        end
    endtask

    task automatic test_store_timeout();
        logic [9:0] e;
        int npc, nwe;
        start({7'b0, 5'd2, 5'd1, 3'b010, 5'd4, 7'b0100011}, 1'b0);
        npc = 0;
        nwe = 0;
        #1;
        for (int c = 1; c <= 22; c++) begin
            if (c > 1) step();
            npc += int'(ctl0[9]);
            nwe += int'(ctl0[5]);
            if (c == 3)                 e = 10'b0010000000;
            else if (c >= 4 && c <= 18) e = 10'b0010100000;
            else                        e = 10'b0;
            checks++;
            if (ctl0 !== e) begin
                errors++;
                $display("FAIL store_timeout cycle %0d: ctl=%b expected %b", c, ctl0, e);
            end
            if (c >= 19) begin
                checks++;
                if (bus0.busErr !== 1'b1 || bus0.illegalInstr !== 1'b0) begin
                    errors++;
                    $display("FAIL store_timeout flags cycle %0d: busErr=%b illegal=%b expected 1 0",
                             c, bus0.busErr, bus0.illegalInstr);
                end
            end
        end
        checks++;
        if (npc != 0 || nwe != 15) begin
            errors++;
            $display("FAIL store_timeout_counts: pcEn=%0d dataWe=%0d expected 0 15", npc, nwe);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus0.busErr !== 1'b0) begin
            errors++;
            $display("FAIL store_timeout_reset: busErr=%b expected 0", bus0.busErr);
        end
    endtask

    task automatic test_store_ready_at_limit();
        logic [9:0] e;
        start({7'b0, 5'd2, 5'd1, 3'b010, 5'd4, 7'b0100011}, 1'b0);
        for (int c = 1; c <= 19; c++) begin
            if (c > 1) step();
            ready = (c == 18);
            #1;
            if (c == 18)      e = 10'b1010100000;
            else if (c == 19) e = 10'b0;
            else              continue;
            checks++;
            if (ctl0 !== e || bus0.busErr !== 1'b0) begin
                errors++;
                $display("FAIL store_limit cycle %0d: ctl=%b busErr=%b expected %b 0", c, ctl0, bus0.busErr, e);
            end
        end
        ready = 1'b0;
    endtask

    task automatic test_illegal();
        logic [31:0] bad[2];
        bad[0] = 32'h0000007F;
        bad[1] = {7'b0, 5'd2, 5'd1, 3'b010, 5'b01000, 7'b1100011};
        for (int t = 0; t < 2; t++) begin
            start(bad[t], 1'b0);
            #1;
            step();
            checks++;
            if (bus0.illegalInstr !== 1'b0) begin
                errors++;
                $display("FAIL illegal[%0d] decode: illegal=%b expected 0", t, bus0.illegalInstr);
            end
            for (int c = 3; c <= 5; c++) begin
                step();
                checks++;
                if (bus0.illegalInstr !== 1'b1 || ctl0 !== 10'b0) begin
                    errors++;
                    $display("FAIL illegal[%0d] cycle %0d: illegal=%b ctl=%b expected 1 0", t, c,
                             bus0.illegalInstr, ctl0);
                end
            end
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus0.illegalInstr !== 1'b0 || bus0.busErr !== 1'b0) begin
            errors++;
            $display("FAIL illegal_reset: illegal=%b busErr=%b expected 0 0", bus0.illegalInstr, bus0.busErr);
        end
        start(32'h002081B3, 1'b0);
        #1;
        step();
        step();
        checks++;
        if (ctl0 !== 10'b1100000000) begin
            errors++;
            $display("FAIL after_trap_reset: ctl=%b expected 1100000000", ctl0);
        end
    endtask

    task automatic test_reset_mid_load();
        start({12'd4, 5'd1, 3'b010, 5'd3, 7'b0000011}, 1'b0);
        #1;
        step();
        step();
        step();
        step();
        checks++;
        if (ctl0 !== 10'b0010010000) begin
            errors++;
            $display("FAIL mid_load_pre: ctl=%b expected 0010010000", ctl0);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (ctl0 !== 10'b0) begin
            errors++;
            $display("FAIL mid_load_reset: ctl=%b expected 0", ctl0);
        end
    endtask

    task automatic test_no_handshake();
        logic [9:0] e;
        start({7'b0, 5'd2, 5'd1, 3'b010, 5'd4, 7'b0100011}, 1'b0);
        #1;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) step();
            if (c == 3)      e = 10'b0010000000;
            else if (c == 4) e = 10'b1010100000;
            else             e = 10'b0;
            checks++;
            if (ctl1 !== e) begin
                errors++;
                $display("FAIL no_handshake cycle %0d: ctl=%b expected %b", c, ctl1, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_branch();
        test_load_wait();
        test_store_timeout();
        test_store_ready_at_limit();
        test_illegal();
        test_reset_mid_load();
        test_no_handshake();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
